// File: rtl/computer_system_pkg.sv
// Shared definitions for the RV32I computer system command arbiter.
// Holds the host command byte codes, the NAK reply byte, the arbiter
// state encoding and the grant target encoding, plus the command decoder.
package computer_system_pkg;

    localparam logic [7:0] CMD_LOAD     = 8'h1C;
    localparam logic [7:0] CMD_RUN_CONT = 8'hCE;
    localparam logic [7:0] CMD_RUN_STEP = 8'hDE;
    localparam logic [7:0] NAK_BYTE     = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK_START,
        S_ACK_BUSY,
        S_ACK_DONE,
        S_GRANT,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_LOADER,
        TGT_DEBUG
    } target_t;

    // Map a received command byte to the unit that will own the link.
    function automatic target_t decode_target(input logic [7:0] cmd);
        target_t tgt;
        case (cmd)
            CMD_LOAD:                   tgt = TGT_LOADER;
            CMD_RUN_CONT, CMD_RUN_STEP: tgt = TGT_DEBUG;
            default:                    tgt = TGT_NONE;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/uart_cmd_arbiter.sv
// Command arbiter: sole owner of the host UART link.
// Decodes one command byte from RX, echoes it (or replies NAK) on TX, then
// hands the link and control to the loader or the debug unit until that
// unit reports done. At most one grant is high at any time.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   rx_data_i, rx_ready_i         UART RX byte and its valid pulse
//   tx_data_o, tx_start_o         UART TX byte and start pulse
//   tx_busy_i                     UART TX busy
//   loader_*                      grant / done / gated RX / TX for the loader
//   debug_*                       grant / mode / done / gated RX / TX for debug
//   busy_o                        arbiter is not idle
//   nak_count_o                   saturating count of rejected command bytes
module uart_cmd_arbiter
    import computer_system_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_busy_i,
    output logic       loader_grant_o,
    input  logic       loader_done_i,
    output logic       loader_rx_ready_o,
    input  logic [7:0] loader_tx_data_i,
    input  logic       loader_tx_start_i,
    output logic       debug_grant_o,
    output logic       debug_exec_mode_o,
    input  logic       debug_done_i,
    output logic       debug_rx_ready_o,
    input  logic [7:0] debug_tx_data_i,
    input  logic       debug_tx_start_i,
    output logic       busy_o,
    output logic [7:0] nak_count_o
);

    state_t     state_q, state_d;
    logic [7:0] cmd_q;
    target_t    target_q;
    logic       mode_q;
    logic [7:0] nak_q;
    logic       nak_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cmd_q    <= 8'h00;
            target_q <= TGT_NONE;
            mode_q   <= 1'b0;
            nak_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            // Commands are only latched from idle; bytes seen while an
            // ACK is in flight or a unit is granted never touch cmd_q.
            if (state_q == S_IDLE && rx_ready_i) begin
                cmd_q    <= rx_data_i;
                target_q <= decode_target(rx_data_i);
                mode_q   <= (rx_data_i == CMD_RUN_CONT);
            end
            if (nak_inc && nak_q != 8'hFF) begin
                nak_q <= nak_q + 8'h01;
            end
        end
    end

    // Grants, routing enables and exec mode depend only on registered
    // state, so a reset drops them in the same instant.
    always_comb begin
        state_d           = state_q;
        tx_data_o         = 8'h00;
        tx_start_o        = 1'b0;
        loader_grant_o    = 1'b0;
        loader_rx_ready_o = 1'b0;
        debug_grant_o     = 1'b0;
        debug_exec_mode_o = 1'b0;
        debug_rx_ready_o  = 1'b0;
        nak_inc           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_ready_i) state_d = S_ACK_START;
            end
            S_ACK_START: begin
                tx_data_o = (target_q != TGT_NONE) ? cmd_q : NAK_BYTE;
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    nak_inc    = (target_q == TGT_NONE);
                    state_d    = S_ACK_BUSY;
                end
            end
            S_ACK_BUSY: begin
                if (tx_busy_i) state_d = S_ACK_DONE;
            end
            S_ACK_DONE: begin
                if (!tx_busy_i) state_d = (target_q != TGT_NONE) ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                case (target_q)
                    TGT_LOADER: begin
                        loader_grant_o    = 1'b1;
                        loader_rx_ready_o = rx_ready_i;
                        tx_data_o         = loader_tx_data_i;
                        tx_start_o        = loader_tx_start_i;
                        if (loader_done_i) state_d = S_RELEASE;
                    end
                    TGT_DEBUG: begin
                        debug_grant_o     = 1'b1;
                        debug_exec_mode_o = mode_q;
                        debug_rx_ready_o  = rx_ready_i;
                        tx_data_o         = debug_tx_data_i;
                        tx_start_o        = debug_tx_start_i;
                        if (debug_done_i) state_d = S_RELEASE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_RELEASE: begin
                // Hold off until the owning unit drops done so a stale
                // done level cannot cut short the next grant.
                if (target_q == TGT_LOADER) begin
                    if (!loader_done_i) state_d = S_IDLE;
                end else if (target_q == TGT_DEBUG) begin
                    if (!debug_done_i) state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign nak_count_o = nak_q;

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Directed self-checking bench for uart_cmd_arbiter.
module tb_uart_cmd_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_ready_i = 1'b0;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_busy_i;
    logic       loader_grant_o;
    logic       loader_done_i = 1'b0;
    logic       loader_rx_ready_o;
    logic [7:0] loader_tx_data_i = 8'h00;
    logic       loader_tx_start_i = 1'b0;
    logic       debug_grant_o;
    logic       debug_exec_mode_o;
    logic       debug_done_i = 1'b0;
    logic       debug_rx_ready_o;
    logic [7:0] debug_tx_data_i = 8'h00;
    logic       debug_tx_start_i = 1'b0;
    logic       busy_o;
    logic [7:0] nak_count_o;

    int total = 0;
    int bad   = 0;

    // UART TX model: busy for 3 cycles after each start, plus a manual hold.
    logic       ext_busy = 1'b0;
    logic [1:0] busy_cnt = 2'd0;
    assign tx_busy_i = ext_busy | (busy_cnt != 2'd0);

    always @(posedge clk_i) begin
        if (tx_start_o)            busy_cnt <= 2'd3;
        else if (busy_cnt != 2'd0) busy_cnt <= busy_cnt - 2'd1;
    end

    always #5 clk_i = ~clk_i;

    uart_cmd_arbiter dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rx_data_i         (rx_data_i),
        .rx_ready_i        (rx_ready_i),
        .tx_data_o         (tx_data_o),
        .tx_start_o        (tx_start_o),
        .tx_busy_i         (tx_busy_i),
        .loader_grant_o    (loader_grant_o),
        .loader_done_i     (loader_done_i),
        .loader_rx_ready_o (loader_rx_ready_o),
        .loader_tx_data_i  (loader_tx_data_i),
        .loader_tx_start_i (loader_tx_start_i),
        .debug_grant_o     (debug_grant_o),
        .debug_exec_mode_o (debug_exec_mode_o),
        .debug_done_i      (debug_done_i),
        .debug_rx_ready_o  (debug_rx_ready_o),
        .debug_tx_data_i   (debug_tx_data_i),
        .debug_tx_start_i  (debug_tx_start_i),
        .busy_o            (busy_o),
        .nak_count_o       (nak_count_o)
    );

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    // Pulse rx_ready for one cycle; returns in the cycle after the pulse.
    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data_i  = b;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        #1;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!(loader_grant_o || debug_grant_o) && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic release_unit(input bit dbg);
        if (dbg) debug_done_i = 1'b1; else loader_done_i = 1'b1;
        tick();
        tick();
        debug_done_i  = 1'b0;
        loader_done_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        total++; if (tx_start_o !== 1'b0) begin bad++; $display("FAIL reset_tx_start got %b want 0", tx_start_o); end
        total++; if (tx_data_o !== 8'h00) begin bad++; $display("FAIL reset_tx_data got %h want 00", tx_data_o); end
        total++; if ({loader_grant_o, debug_grant_o, debug_exec_mode_o} !== 3'b000) begin bad++; $display("FAIL reset_grants got %b want 000", {loader_grant_o, debug_grant_o, debug_exec_mode_o}); end
        total++; if ({loader_rx_ready_o, debug_rx_ready_o, busy_o} !== 3'b000) begin bad++; $display("FAIL reset_misc got %b want 000", {loader_rx_ready_o, debug_rx_ready_o, busy_o}); end
        total++; if (nak_count_o !== 8'h00) begin bad++; $display("FAIL reset_nak got %h want 00", nak_count_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_debug_cont();
        int n;
        send_byte(8'hCE);
        total++; if (tx_start_o !== 1'b1) begin bad++; $display("FAIL cont_ack_start got %b want 1", tx_start_o); end
        total++; if (tx_data_o !== 8'hCE) begin bad++; $display("FAIL cont_ack_data got %h want CE", tx_data_o); end
        wait_grant(n);
        total++; if (n !== 5) begin bad++; $display("FAIL cont_grant_latency got %0d want 5", n); end
        total++; if ({debug_grant_o, debug_exec_mode_o, loader_grant_o} !== 3'b110) begin bad++; $display("FAIL cont_grant got %b want 110", {debug_grant_o, debug_exec_mode_o, loader_grant_o}); end
        debug_done_i = 1'b1;
        #1;
        total++; if (debug_grant_o !== 1'b1) begin bad++; $display("FAIL cont_grant_same_cycle got %b want 1", debug_grant_o); end
        tick();
        total++; if ({debug_grant_o, busy_o} !== 2'b01) begin bad++; $display("FAIL cont_release got %b want 01", {debug_grant_o, busy_o}); end
        debug_done_i = 1'b0;
        tick();
        total++; if ({debug_grant_o, busy_o} !== 2'b00) begin bad++; $display("FAIL cont_idle got %b want 00", {debug_grant_o, busy_o}); end
    endtask

    task automatic test_rx_routing();
        int  n;
        bit  broke;
        send_byte(8'hDE);
        wait_grant(n);
        total++; if ({debug_grant_o, debug_exec_mode_o} !== 2'b10) begin bad++; $display("FAIL step_grant got %b want 10", {debug_grant_o, debug_exec_mode_o}); end
        rx_data_i  = 8'hAE;
        rx_ready_i = 1'b1;
        #1;
        total++; if ({debug_rx_ready_o, loader_rx_ready_o, tx_start_o} !== 3'b100) begin bad++; $display("FAIL step_rx_route got %b want 100", {debug_rx_ready_o, loader_rx_ready_o, tx_start_o}); end
        tick();
        rx_ready_i    = 1'b0;
        loader_done_i = 1'b1;
        broke = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!debug_grant_o || tx_start_o || loader_grant_o) broke = 1'b1;
        end
        total++; if (broke !== 1'b0) begin bad++; $display("FAIL step_hold_grant got %b want 0", broke); end
        loader_done_i    = 1'b0;
        debug_tx_data_i  = 8'h77;
        debug_tx_start_i = 1'b1;
        #1;
        total++; if ({tx_start_o, tx_data_o} !== {1'b1, 8'h77}) begin bad++; $display("FAIL step_tx_route got %b_%h want 1_77", tx_start_o, tx_data_o); end
        tick();
        debug_tx_start_i = 1'b0;
        release_unit(1'b1);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL step_idle got %b want 0", busy_o); end
    endtask

    task automatic test_nak();
        int n;
        bit granted;
        send_byte(8'h55);
        total++; if ({tx_start_o, tx_data_o} !== {1'b1, 8'h3F}) begin bad++; $display("FAIL nak_ack got %b_%h want 1_3F", tx_start_o, tx_data_o); end
        granted = 1'b0;
        n = 0;
        while (busy_o && n < 50) begin
            tick();
            n++;
            if (loader_grant_o || debug_grant_o) granted = 1'b1;
        end
        total++; if ({busy_o, granted} !== 2'b00) begin bad++; $display("FAIL nak_no_grant got %b want 00", {busy_o, granted}); end
        total++; if (nak_count_o !== 8'h01) begin bad++; $display("FAIL nak_count_one got %h want 01", nak_count_o); end
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hA0);
            wait_idle(n);
        end
        total++; if (nak_count_o !== 8'hFF) begin bad++; $display("FAIL nak_count_255 got %h want FF", nak_count_o); end
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h00);
            wait_idle(n);
        end
        total++; if (nak_count_o !== 8'hFF) begin bad++; $display("FAIL nak_saturate got %h want FF", nak_count_o); end
    endtask

    task automatic test_loader_busy();
        int n;
        bit early;
        ext_busy = 1'b1;
        send_byte(8'h1C);
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_start_o) early = 1'b1;
            tick();
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL load_start_held got %b want 0", early); end
        ext_busy = 1'b0;
        #1;
        total++; if ({tx_start_o, tx_data_o} !== {1'b1, 8'h1C}) begin bad++; $display("FAIL load_ack got %b_%h want 1_1C", tx_start_o, tx_data_o); end
        wait_grant(n);
        total++; if ({loader_grant_o, debug_grant_o} !== 2'b10) begin bad++; $display("FAIL load_grant got %b want 10", {loader_grant_o, debug_grant_o}); end
        loader_tx_data_i  = 8'h42;
        loader_tx_start_i = 1'b1;
        #1;
        total++; if ({tx_start_o, tx_data_o} !== {1'b1, 8'h42}) begin bad++; $display("FAIL load_tx_route got %b_%h want 1_42", tx_start_o, tx_data_o); end
        loader_tx_start_i = 1'b0;
        debug_tx_data_i   = 8'h99;
        debug_tx_start_i  = 1'b1;
        debug_done_i      = 1'b1;
        #1;
        total++; if ({tx_start_o, tx_data_o} !== {1'b0, 8'h42}) begin bad++; $display("FAIL load_debug_tx_ignored got %b_%h want 0_42", tx_start_o, tx_data_o); end
        tick();
        total++; if (loader_grant_o !== 1'b1) begin bad++; $display("FAIL load_debug_done_ignored got %b want 1", loader_grant_o); end
        debug_tx_start_i = 1'b0;
        debug_done_i     = 1'b0;
        release_unit(1'b0);
        total++; if ({busy_o, loader_grant_o} !== 2'b00) begin bad++; $display("FAIL load_idle got %b want 00", {busy_o, loader_grant_o}); end
    endtask

    task automatic test_ignore_and_reset();
        int n;
        send_byte(8'h1C);
        // now in the ACK_START cycle; next cycle is ACK_BUSY
        tick();
        rx_data_i  = 8'hCE;
        rx_ready_i = 1'b1;
        #1;
        total++; if ({tx_start_o, debug_rx_ready_o, loader_rx_ready_o} !== 3'b000) begin bad++; $display("FAIL ackbusy_rx_ignored got %b want 000", {tx_start_o, debug_rx_ready_o, loader_rx_ready_o}); end
        tick();
        rx_ready_i = 1'b0;
        wait_grant(n);
        total++; if ({loader_grant_o, debug_grant_o, debug_exec_mode_o} !== 3'b100) begin bad++; $display("FAIL ackbusy_cmd_kept got %b want 100", {loader_grant_o, debug_grant_o, debug_exec_mode_o}); end
        rst_ni = 1'b0;
        #1;
        total++; if ({loader_grant_o, debug_grant_o, busy_o} !== 3'b000) begin bad++; $display("FAIL async_reset_grants got %b want 000", {loader_grant_o, debug_grant_o, busy_o}); end
        total++; if (nak_count_o !== 8'h00) begin bad++; $display("FAIL async_reset_nak got %h want 00", nak_count_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        total++; if ({busy_o, loader_grant_o, tx_data_o} !== {2'b00, 8'h00}) begin bad++; $display("FAIL post_reset_idle got %b_%b_%h want 0_0_00", busy_o, loader_grant_o, tx_data_o); end
    endtask

    initial begin
        test_reset();
        test_debug_cont();
        test_rx_routing();
        test_nak();
        test_loader_busy();
        test_ignore_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
